// File: rtl/blit_read_cache.sv
// rtl/blit_read_cache.sv - fully-associative read cache for the blitter source pipeline
module blit_read_cache #(
    parameter int ADDR_W     = 26,
    parameter int LINE_BYTES = 64,
    parameter int NUM_LINES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p3_src_addr,
    input  logic [1:0]        p3_op,
    input  logic              p3_write,
    input  logic [1:0]        p3_size,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       p4_src_data,
    output logic              p4_write,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ack,
    input  logic [31:0]       sdram_rdata,
    input  logic              sdram_rdvalid,
    input  logic              sdram_complete
);

    localparam int WPL   = LINE_BYTES / 4;
    localparam int OFS_W = $clog2(LINE_BYTES);
    localparam int WI_W  = OFS_W - 2;
    localparam int TAG_W = ADDR_W - OFS_W;
    localparam int LI_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [31:0]          mem  [NUM_LINES][WPL];
    logic [NUM_LINES-1:0] valid;
    logic [LI_W-1:0]      rr_ptr, victim, fill_line, hit_idx;
    logic [WI_W-1:0]      wptr;
    logic                 flush_pending;

    logic [TAG_W-1:0] req_tag;
    logic [WI_W-1:0]  word_idx;
    logic             do_read, hit, found_free;
    logic [31:0]      hit_word, lane_data;

    assign req_tag  = p3_src_addr[ADDR_W-1:OFS_W];
    assign word_idx = p3_src_addr[OFS_W-1:2];
    assign do_read  = p3_write && (p3_op == 2'b01);
    assign stall    = do_read && !hit && !reset;
    assign sdram_req = (state_q == S_REQ);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!hit && valid[i] && tags[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = LI_W'(i);
            end
        end
    end

    // Lowest invalid line wins; round-robin only once every line is live.
    always_comb begin
        victim     = rr_ptr;
        found_free = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!found_free && !valid[i]) begin
                victim     = LI_W'(i);
                found_free = 1'b1;
            end
        end
    end

    always_comb begin
        hit_word  = mem[hit_idx][word_idx];
        lane_data = hit_word;
        case (p3_size)
            2'd0: begin
                case (p3_src_addr[1:0])
                    2'd0: lane_data = {24'b0, hit_word[7:0]};
                    2'd1: lane_data = {24'b0, hit_word[15:8]};
                    2'd2: lane_data = {24'b0, hit_word[23:16]};
                    default: lane_data = {24'b0, hit_word[31:24]};
                endcase
            end
            2'd1: lane_data = p3_src_addr[1] ? {16'b0, hit_word[31:16]}
                                             : {16'b0, hit_word[15:0]};
            default: lane_data = hit_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (stall) state_d = S_REQ;
            S_REQ:  if (sdram_ack) state_d = S_FILL;
            S_FILL: if (sdram_complete) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid         <= '0;
            rr_ptr        <= '0;
            wptr          <= '0;
            flush_pending <= 1'b0;
            fill_line     <= '0;
            sdram_addr    <= '0;
            p4_write      <= 1'b0;
            p4_src_data   <= '0;
        end else begin
            p4_write <= p3_write && !stall;
            if (do_read && hit) p4_src_data <= lane_data;

            case (state_q)
                S_IDLE: begin
                    if (flush) valid <= '0;
                    if (stall) begin
                        fill_line     <= victim;
                        valid[victim] <= 1'b0;
                        sdram_addr    <= {req_tag, {OFS_W{1'b0}}};
                        wptr          <= '0;
                    end
                end
                S_REQ: begin
                    if (flush) valid <= '0;
                end
                S_FILL: begin
                    if (flush) begin
                        valid         <= '0;
                        flush_pending <= 1'b1;
                    end
                    if (sdram_rdvalid) wptr <= wptr + 1'b1;
                    if (sdram_complete) begin
                        // A flush seen anywhere during the burst leaves the line invalid.
                        valid[fill_line] <= !(flush_pending || flush);
                        rr_ptr <= (rr_ptr == LI_W'(NUM_LINES - 1)) ? '0 : rr_ptr + 1'b1;
                        flush_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays need no reset; validity is tracked by valid[].
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && stall) tags[victim] <= req_tag;
        if (!reset && state_q == S_FILL && sdram_rdvalid) mem[fill_line][wptr] <= sdram_rdata;
    end

endmodule

// File: tb/tb_blit_read_cache.sv
// tb/tb_blit_read_cache.sv - randomized self-checking bench for blit_read_cache
module tb_blit_read_cache;

    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] p3_src_addr;
    logic [1:0]  p3_op;
    logic        p3_write;
    logic [1:0]  p3_size;
    logic        flush;
    logic        stall;
    logic [31:0] p4_src_data;
    logic        p4_write;
    logic        sdram_req;
    logic [25:0] sdram_addr;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic        sdram_rdvalid;
    logic        sdram_complete;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] smem [0:4095];
    logic        m_valid [NL];
    logic [19:0] m_tag [NL];
    int          m_rr;

    always #5 clk = ~clk;

    blit_read_cache #(.ADDR_W(26), .LINE_BYTES(64), .NUM_LINES(NL)) dut (
        .clk(clk), .reset(reset),
        .p3_src_addr(p3_src_addr), .p3_op(p3_op), .p3_write(p3_write), .p3_size(p3_size),
        .flush(flush), .stall(stall), .p4_src_data(p4_src_data), .p4_write(p4_write),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid), .sdram_complete(sdram_complete)
    );

    function automatic logic model_hit(logic [19:0] t);
        for (int i = 0; i < NL; i++)
            if (m_valid[i] && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_victim();
        for (int i = 0; i < NL; i++)
            if (!m_valid[i]) return i;
        return m_rr;
    endfunction

    function automatic logic [31:0] exp_pix(logic [25:0] a, logic [1:0] sz);
        logic [31:0] w;
        w = smem[a[13:2]];
        if (sz == 2'd0) return (w >> (8 * a[1:0])) & 32'hFF;
        if (sz == 2'd1) return (w >> (16 * a[1])) & 32'hFFFF;
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; p3_write = 1'b0; flush = 1'b0;
        sdram_ack = 1'b0; sdram_rdvalid = 1'b0; sdram_complete = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Acts as the SDRAM for one burst; returns at the negedge after the completing edge.
    task automatic serve_fill(input logic [25:0] la, input int flush_at, output bit ok);
        int waitc;
        int k;
        bit comb;
        logic [11:0] idx;
        ok = 1'b0;
        waitc = 0;
        while (sdram_req !== 1'b1 && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (sdram_req !== 1'b1) begin
            n_errors++;
            $display("FAIL req_timeout: sdram_req=%b after %0d cycles, required 1", sdram_req, waitc);
            return;
        end
        n_checks++;
        if (sdram_addr !== la) begin
            n_errors++;
            $display("FAIL req_addr: sdram_addr=%h required %h", sdram_addr, la);
        end
        k = $urandom_range(0, 2);
        repeat (k) begin
            @(negedge clk);
            n_checks++;
            if (sdram_req !== 1'b1 || sdram_addr !== la) begin
                n_errors++;
                $display("FAIL req_hold: req=%b addr=%h required 1 %h", sdram_req, sdram_addr, la);
            end
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        n_checks++;
        if (sdram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL req_drop: sdram_req=%b required 0", sdram_req);
        end
        comb = 1'($urandom_range(0, 1));
        for (int w = 0; w < 16; w++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            idx = la[13:2] + 12'(w);
            sdram_rdvalid  = 1'b1;
            sdram_rdata    = smem[idx];
            flush          = (w == flush_at);
            sdram_complete = comb && (w == 15);
            @(negedge clk);
            sdram_rdvalid = 1'b0; flush = 1'b0; sdram_complete = 1'b0;
        end
        if (!comb) begin
            sdram_complete = 1'b1;
            @(negedge clk);
            sdram_complete = 1'b0;
        end
        n_checks++;
        if (p4_write !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_bubble: p4_write=%b required 0", p4_write);
        end
        ok = 1'b1;
    endtask

    task automatic do_read(input logic [25:0] a, input logic [1:0] sz, input int flush_at,
                           output logic [31:0] got);
        logic miss;
        logic [19:0] t;
        int v;
        int fa;
        bit ok;
        t = a[25:6];
        @(negedge clk);
        p3_src_addr = a; p3_size = sz; p3_op = 2'b01; p3_write = 1'b1;
        #1;
        miss = !model_hit(t);
        n_checks++;
        if (stall !== miss) begin
            n_errors++;
            $display("FAIL stall_req: addr=%h stall=%b required %b", a, stall, miss);
        end
        fa = flush_at;
        while (miss) begin
            v = model_victim();
            m_valid[v] = 1'b0;
            serve_fill({t, 6'b0}, fa, ok);
            if (fa >= 0) begin
                for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            end else begin
                m_valid[v] = 1'b1;
                m_tag[v] = t;
            end
            m_rr = (m_rr + 1) % NL;
            fa = -1;
            #1;
            miss = !model_hit(t);
            n_checks++;
            if (stall !== miss) begin
                n_errors++;
                $display("FAIL stall_after_fill: addr=%h stall=%b required %b", a, stall, miss);
            end
            if (!ok) break;
        end
        @(negedge clk);
        n_checks++;
        if (p4_write !== 1'b1 || p4_src_data !== exp_pix(a, sz)) begin
            n_errors++;
            $display("FAIL read_data: addr=%h size=%0d p4_write=%b data=%h required 1 %h",
                     a, sz, p4_write, p4_src_data, exp_pix(a, sz));
        end
        got = p4_src_data;
        p3_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        sdram_ack = 1'b0; sdram_rdvalid = 1'b0; sdram_complete = 1'b0; sdram_rdata = '0;
        p3_src_addr = 26'h45; p3_op = 2'b01; p3_size = 2'd0; p3_write = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || sdram_req !== 1'b0 || sdram_addr !== 26'h0 ||
            p4_write !== 1'b0 || p4_src_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: stall=%b req=%b addr=%h p4w=%b data=%h required all 0",
                     stall, sdram_req, sdram_addr, p4_write, p4_src_data);
        end
        p3_write = 1'b0;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        logic [31:0] got;
        reset_dut();
        do_read(26'h45, 2'd0, -1, got);
        n_checks++;
        if (got !== 32'h000000BB) begin
            n_errors++;
            $display("FAIL cold_miss_byte: got %h required 000000bb", got);
        end
    endtask

    task automatic test_hit_sizes();
        logic [31:0] got;
        do_read(26'h46, 2'd1, -1, got);
        n_checks++;
        if (got !== 32'h0000DDCC) begin
            n_errors++;
            $display("FAIL hit_half: got %h required 0000ddcc", got);
        end
        do_read(26'h47, 2'd2, -1, got);
        n_checks++;
        if (got !== 32'hDDCCBBAA) begin
            n_errors++;
            $display("FAIL hit_word: got %h required ddccbbaa", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] a;
        logic [1:0]  sz;
        logic [31:0] prev_exp;
        prev_exp = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (p4_write !== 1'b1 || p4_src_data !== prev_exp) begin
                    n_errors++;
                    $display("FAIL b2b_data[%0d]: p4w=%b data=%h required 1 %h",
                             i, p4_write, p4_src_data, prev_exp);
                end
            end
            a = 26'h40 + 26'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            p3_src_addr = a; p3_size = sz; p3_op = 2'b01; p3_write = 1'b1;
            #1;
            n_checks++;
            if (stall !== !model_hit(a[25:6])) begin
                n_errors++;
                $display("FAIL b2b_stall[%0d]: stall=%b required %b", i, stall, !model_hit(a[25:6]));
            end
            prev_exp = exp_pix(a, sz);
        end
        @(negedge clk);
        n_checks++;
        if (p4_write !== 1'b1 || p4_src_data !== prev_exp) begin
            n_errors++;
            $display("FAIL b2b_last: p4w=%b data=%h required 1 %h", p4_write, p4_src_data, prev_exp);
        end
        p3_write = 1'b0;
    endtask

    task automatic test_eviction();
        logic [31:0] got;
        logic [25:0] seq [7];
        seq = '{26'h000, 26'h040, 26'h080, 26'h0C0, 26'h100, 26'h040, 26'h000};
        reset_dut();
        for (int i = 0; i < 7; i++)
            do_read(seq[i] + 26'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), -1, got);
    endtask

    task automatic test_flush_mid_fill();
        logic [31:0] got;
        reset_dut();
        do_read(26'h000, 2'd2, -1, got);
        do_read(26'h040, 2'd2, -1, got);
        do_read(26'h208, 2'd2, 5, got);
        do_read(26'h004, 2'd1, -1, got);
        do_read(26'h048, 2'd0, -1, got);
    endtask

    task automatic test_flush_on_hit();
        logic [31:0] got;
        reset_dut();
        do_read(26'h040, 2'd2, -1, got);
        @(negedge clk);
        p3_src_addr = 26'h48; p3_size = 2'd2; p3_op = 2'b01; p3_write = 1'b1; flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_hit_stall: stall=%b required 0", stall);
        end
        @(negedge clk);
        flush = 1'b0; p3_write = 1'b0;
        n_checks++;
        if (p4_write !== 1'b1 || p4_src_data !== exp_pix(26'h48, 2'd2)) begin
            n_errors++;
            $display("FAIL flush_hit_data: p4w=%b data=%h required 1 %h",
                     p4_write, p4_src_data, exp_pix(26'h48, 2'd2));
        end
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        do_read(26'h48, 2'd2, -1, got);
    endtask

    task automatic test_reset_mid(input bit in_fill);
        logic [31:0] got;
        int waitc;
        reset_dut();
        do_read(26'h44, 2'd2, -1, got);
        @(negedge clk);
        p3_src_addr = 26'h300; p3_op = 2'b01; p3_size = 2'd0; p3_write = 1'b1;
        waitc = 0;
        while (sdram_req !== 1'b1 && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (sdram_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_req: sdram_req=%b required 1", sdram_req);
        end
        if (in_fill) begin
            sdram_ack = 1'b1;
            @(negedge clk);
            sdram_ack = 1'b0;
            repeat (4) begin
                sdram_rdvalid = 1'b1; sdram_rdata = $urandom;
                @(negedge clk);
            end
            sdram_rdvalid = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_stall: stall=%b required 0", stall);
        end
        @(negedge clk);
        reset = 1'b0; p3_write = 1'b0;
        n_checks++;
        if (sdram_req !== 1'b0 || sdram_addr !== 26'h0 || p4_write !== 1'b0 || p4_src_data !== 32'h0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs[fill=%0d]: req=%b addr=%h p4w=%b data=%h required all 0",
                     in_fill, sdram_req, sdram_addr, p4_write, p4_src_data);
        end
        model_clear();
        sdram_rdvalid = 1'b1; sdram_complete = 1'b1; sdram_rdata = $urandom;
        repeat (2) @(negedge clk);
        sdram_rdvalid = 1'b0; sdram_complete = 1'b0;
        n_checks++;
        if (sdram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_stray: sdram_req=%b required 0", sdram_req);
        end
        do_read(26'h44, 2'd2, -1, got);
    endtask

    task automatic test_non_read();
        logic [31:0] got;
        reset_dut();
        @(negedge clk);
        p3_src_addr = 26'h45; p3_op = 2'b10; p3_size = 2'd0; p3_write = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL nonread_stall: stall=%b required 0", stall);
        end
        @(negedge clk);
        p3_write = 1'b0;
        n_checks++;
        if (p4_write !== 1'b1 || sdram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL nonread_pass: p4w=%b req=%b required 1 0", p4_write, sdram_req);
        end
        @(negedge clk);
        n_checks++;
        if (p4_write !== 1'b0 || sdram_req !== 1'b0) begin
            n_errors++;
            $display("FAIL nonread_after: p4w=%b req=%b required 0 0", p4_write, sdram_req);
        end
        do_read(26'h45, 2'd0, -1, got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [25:0] bases [6];
        logic [25:0] a;
        int fa;
        reset_dut();
        for (int i = 0; i < 6; i++) bases[i] = {20'($urandom), 6'b0};
        for (int n = 0; n < 40; n++) begin
            a = bases[$urandom_range(0, 5)] + 26'($urandom_range(0, 63));
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_read(a, 2'($urandom_range(0, 3)), fa, got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) smem[i] = $urandom;
        smem[17] = 32'hDDCCBBAA;
        model_clear();
        test_reset();
        test_cold_miss();
        test_hit_sizes();
        test_back_to_back();
        test_eviction();
        test_flush_mid_fill();
        test_flush_on_hit();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_non_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
